// File: rtl/slice_fill_sequencer.sv
// slice_fill_sequencer
// Sequences a bank of NSLICE buffer_slice shift registers used as line
// buffers so that row r ends up holding line r of a frame.
//
// Ports
//   clk          single clock, all state updates on posedge
//   rst          asynchronous active-low reset
//   start        begin a frame (honoured only in IDLE)
//   in_valid     upstream sample valid
//   in_data      upstream sample
//   in_ready     sample accepted when in_valid && in_ready
//   slice_wen    per-slice write enable (one-hot or zero)
//   slice_pop    per-slice pop (one-hot or zero)
//   slice_din    data shared by all slices
//   row          current row pointer
//   busy         high whenever not IDLE
//   frame_valid  all rows filled, window contents stable
//   frame_ready  consumer releases the frame
module slice_fill_sequencer #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned SLICE    = 8,
  parameter int unsigned NSLICE   = 3,
  parameter int unsigned LINE_LEN = 8,
  localparam int unsigned RW = (NSLICE > 1) ? $clog2(NSLICE) : 1,
  localparam int unsigned CW = $clog2(LINE_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic [NSLICE-1:0] slice_wen,
  output logic [NSLICE-1:0] slice_pop,
  output logic [DWIDTH-1:0] slice_din,
  output logic [RW-1:0]     row,
  output logic              busy,
  output logic              frame_valid,
  input  logic              frame_ready
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [NSLICE-1:0] row_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign row_sel = NSLICE'(1) << row_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    in_ready    = 1'b0;
    slice_wen   = '0;
    slice_pop   = '0;
    slice_din   = '0;
    frame_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          row_d   = '0;
          col_d   = '0;
        end
      end

      FILL: begin
        in_ready  = 1'b1;
        slice_din = in_data;
        if (in_valid) begin
          // wen+pop together: old stage0 enters the window, new sample lands in stage0
          slice_wen = row_sel;
          slice_pop = row_sel;
          col_d     = col_q + CW'(1);
          if (col_q == CW'(LINE_LEN - 1)) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        // extra pop pushes the last sample still in stage0 into the window
        slice_pop = row_sel;
        col_d     = '0;
        if (row_q == RW'(NSLICE - 1)) begin
          state_d = HOLD;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = FILL;
        end
      end

      HOLD: begin
        frame_valid = 1'b1;
        if (frame_ready) begin
          state_d = IDLE;
          row_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  assign row  = row_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_slice_fill_sequencer.sv
module tb_slice_fill_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned SL = 4;
  localparam int unsigned NS = 2;
  localparam int unsigned LL = 4;
  localparam int unsigned RW = 1;
  localparam int          FRAME_POS = NS * (LL + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [NS-1:0] slice_wen;
  logic [NS-1:0] slice_pop;
  logic [DW-1:0] slice_din;
  logic [RW-1:0] row;
  logic          busy;
  logic          frame_valid;
  logic          frame_ready = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  slice_fill_sequencer #(
    .DWIDTH  (DW),
    .SLICE   (SL),
    .NSLICE  (NS),
    .LINE_LEN(LL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .slice_wen  (slice_wen),
    .slice_pop  (slice_pop),
    .slice_din  (slice_din),
    .row        (row),
    .busy       (busy),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model of the slice bank driven by the DUT outputs.
  logic [DW-1:0] stage0 [NS];
  logic [DW-1:0] win    [NS][SL];

  function automatic logic [31:0] win_packed(input int s);
    return {win[s][0], win[s][1], win[s][2], win[s][3]};
  endfunction

  // Frame model: position p walks 0..FRAME_POS; inside a row, positions
  // 0..LL-1 take samples and position LL is the flush; FRAME_POS is hold.
  int m_p    = 0;
  bit m_idle = 1'b1;

  always @(negedge clk) begin
    logic [31:0] e_rdy, e_wen, e_pop, e_din, e_row, e_busy, e_fv;
    int r, k;
    e_rdy = 0; e_wen = 0; e_pop = 0; e_din = 0; e_row = 0; e_busy = 0; e_fv = 0;
    r = m_p / (LL + 1);
    k = m_p % (LL + 1);
    if (!rst) begin
      m_idle = 1'b1;
      m_p    = 0;
    end else if (!m_idle) begin
      e_busy = 1;
      if (m_p == FRAME_POS) begin
        e_fv  = 1;
        e_row = NS - 1;
      end else begin
        e_row = r;
        if (k < LL) begin
          e_rdy = 1;
          e_din = in_data;
          if (in_valid) begin
            e_wen = 1 << r;
            e_pop = 1 << r;
          end
        end else begin
          e_pop = 1 << r;
        end
      end
    end
    chk("in_ready", in_ready, e_rdy);
    chk("slice_wen", slice_wen, e_wen);
    chk("slice_pop", slice_pop, e_pop);
    chk("slice_din", slice_din, e_din);
    chk("row", row, e_row);
    chk("busy", busy, e_busy);
    chk("frame_valid", frame_valid, e_fv);

    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        if (slice_pop[s]) begin
          for (int e = SL - 1; e > 0; e--) win[s][e] = win[s][e-1];
          win[s][0] = stage0[s];
        end
        if (slice_wen[s]) stage0[s] = slice_din;
      end
      if (m_idle) begin
        if (start) begin
          m_idle = 1'b0;
          m_p    = 0;
        end
      end else if (m_p == FRAME_POS) begin
        if (frame_ready) m_idle = 1'b1;
      end else if (k == LL || in_valid) begin
        m_p = m_p + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;
  logic [31:0] snap0, snap1;

  initial begin
    // 1: reset
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wen_pop", {slice_wen, slice_pop}, 0);
    chk("rst_din", slice_din, 0);
    chk("rst_row_busy_fv", {row, busy, frame_valid}, 0);
    rst = 1'b1;
    step();

    // 2: row 0 with continuous valid
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_pop", slice_pop, 2'b01);
    chk("flush_wen", slice_wen, 2'b00);
    step();
    chk("row0_window", win_packed(0), 32'h04030201);
    chk("row_after_row0", row, 1);

    // 3: row 1 with gaps; in_valid held high through FLUSH
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 + i);
      step();
      if (i < 3) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        step();
      end
    end
    chk("row1_flush_pop", slice_pop, 2'b10);
    step();
    chk("hold_frame_valid", frame_valid, 1);
    chk("row1_window", win_packed(1), 32'h14131211);

    // 4: hold with frame_ready low, in_valid high
    snap0 = win_packed(0);
    snap1 = win_packed(1);
    repeat (5) step();
    chk("hold_fv_after_wait", frame_valid, 1);
    chk("hold_in_ready", in_ready, 0);
    chk("hold_slice0_frozen", win_packed(0), snap0);
    chk("hold_slice1_frozen", win_packed(1), snap1);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("release_fv", frame_valid, 0);
    chk("release_row_busy", {row, busy}, 0);
    step();
    in_valid = 1'b0;

    // start to frame_valid latency with continuous valid
    start    = 1'b1;
    in_valid = 1'b1;
    n = 0;
    do begin
      in_data = 8'(8'h40 + n);
      step();
      start = 1'b0;
      n++;
    end while (!frame_valid && n < 100);
    chk("latency", n, 11);
    in_valid    = 1'b0;
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;

    // 5: asynchronous reset mid row 0
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA1;
    step();
    in_data = 8'hA2;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_outputs", {in_ready, slice_wen, slice_pop, busy, frame_valid}, 0);
    chk("async_rst_din_row", {slice_din, row}, 0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h31 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("rebuilt_row0", win_packed(0), 32'h34333231);

    // 6: start/frame_ready ignored in FILL; start ignored on the HOLD handshake
    start = 1'b1;
    frame_ready = 1'b1;
    step();
    start = 1'b0;
    frame_ready = 1'b0;
    chk("fill_ignore_row", row, 1);
    chk("fill_ignore_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h51 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("row1_second_frame", win_packed(1), 32'h54535251);
    start = 1'b1;
    frame_ready = 1'b1;
    step();
    start = 1'b0;
    frame_ready = 1'b0;
    step();
    chk("start_on_release_ignored", busy, 0);
    repeat (2) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/slice_fill_sequencer.md
Name: slice_fill_sequencer

Overview:
Controller that sequences a bank of NSLICE buffer_slice shift registers used as line buffers. It accepts a sample stream over a valid/ready handshake and drives each slice's wen/pop/din so that row r holds line r. It inserts the extra flush pop each slice needs, advances the row pointer, and reports a completed frame to the downstream window consumer through a valid/ready handshake.

Parameters:
DWIDTH, 8, sample width; the top level instantiates it with `dwidth_dat.
SLICE, 8, elements per slice; the top level instantiates it with `dwidth_slice.
NSLICE, 3, number of slices/rows in the bank; minimum 1.
LINE_LEN, 8, samples accepted per row; minimum 1.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset; rst=0 resets immediately.
start  input  1  begin a frame; honoured only in IDLE.
in_valid  input  1  upstream sample valid.
in_data  input  DWIDTH  upstream sample.
in_ready  output  1  sample accepted when in_valid and in_ready are both 1.
slice_wen  output  NSLICE  per-slice wen; at most one bit set.
slice_pop  output  NSLICE  per-slice pop; at most one bit set.
slice_din  output  DWIDTH  shared din to all slices.
row  output  clog2(NSLICE) (min 1)  current row pointer.
busy  output  1  high in any state other than IDLE.
frame_valid  output  1  all rows filled; window contents are stable.
frame_ready  input  1  consumer release.

Behaviour:
- Registered state: state, row, col (width clog2(LINE_LEN+1)). All other outputs are combinational from state, row and the in_valid handshake.
- Reset (rst=0, async): state=IDLE, row=0, col=0. All outputs are 0: in_ready, slice_wen, slice_pop, slice_din, busy, frame_valid. Slice contents are not cleared.
- IDLE: outputs 0. start=1 moves to FILL, with row=0 and col=0.
- FILL: in_ready=1.
  - On accept: slice_wen[row]=1, slice_pop[row]=1, slice_din=in_data, col<=col+1.
  - On a no-accept cycle: wen/pop are 0 and col holds.
  - Simultaneous wen+pop moves the prior stage0 into the visible window and loads the new sample into stage0.
  - slice_din equals in_data whenever in FILL. This is don't-care for the slices when wen=0, but the bench checks it.
  - Accepting sample number LINE_LEN (col==LINE_LEN-1) moves to FLUSH.
- FLUSH (exactly 1 cycle): in_ready=0, slice_pop[row]=1, slice_wen=0. This moves the last sample into the window.
  - Then col<=0.
  - If row==NSLICE-1, go to HOLD.
  - Otherwise row<=row+1 and go to FILL.
- HOLD: frame_valid=1, in_ready=0, no wen/pop; slices are frozen.
  - frame_ready=1 moves to IDLE, with row<=0.
  - frame_valid drops the cycle after the handshake.
- Latency: each row takes LINE_LEN accepted samples plus 1 flush cycle. With continuous in_valid, start to frame_valid is NSLICE*(LINE_LEN+1)+1 cycles.
- After flush, a row's window holds the last min(SLICE,LINE_LEN) samples of its line, newest in the lowest element. If LINE_LEN<SLICE, the upper elements keep stale data.
- Ignored events:
  - start outside IDLE.
  - frame_ready outside HOLD.
  - in_valid outside FILL (in_ready=0, nothing consumed).
- start and frame_ready in the same HOLD cycle: the handshake completes and start is ignored, since state is not yet IDLE.
- Reset mid-operation aborts immediately. The partial row in the slices is abandoned, and the next frame overwrites it.
- busy = (state != IDLE).

Test Plan:
All scenarios use DWIDTH=8, SLICE=4, NSLICE=2, LINE_LEN=4.
1. Assert rst=0 for 3 cycles -> every output is 0; row=0; busy=0; frame_valid=0.
2. Pulse start, then feed 0x01..0x04 with in_valid held high -> slice_wen[0]=slice_pop[0]=1 on 4 consecutive cycles; then 1 FLUSH cycle with pop[0]=1, wen=0, in_ready=0; slice0 dout={04,03,02,01}; row becomes 1.
3. Row 1 with in_valid toggled 1,0,1,0 carrying 0x11..0x14 -> wen/pop only on valid cycles; col holds in gaps; FLUSH occurs after the 4th accept; frame_valid rises the cycle after FLUSH, and slice1 dout={14,13,12,11}.
4. Hold frame_ready=0 for 5 cycles in HOLD -> frame_valid stays 1, no wen/pop, in_ready=0, slice outputs unchanged. Then frame_ready=1 -> IDLE next cycle, row=0, frame_valid=0.
5. Drive rst=0 asynchronously mid-row 0, after 2 accepts -> outputs drop to 0 before the next clk edge, state=IDLE. A subsequent start and 4 samples rebuild row 0 correctly.
6. Pulse start during FILL and frame_ready during FILL -> no state, row or col change. Drive in_valid=1 in IDLE/FLUSH/HOLD -> in_ready=0 and no wen.
